// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester the pointer names.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = 2'b00;
      gnt[ptr ? REQ_LOADER : REQ_CORE] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between the core and the loader, with
// round-robin fairness and bounded burst locking.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int W        = 8,
  parameter int A        = 8,
  parameter int MAXBURST = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [1:0]   Req,
  input  logic [1:0]   Lock,
  input  logic [1:0]   We,
  input  logic [A-1:0] Addr0,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] Wdata0,
  input  logic [W-1:0] Wdata1,
  output logic [1:0]   Gnt,
  output logic [1:0]   Rvalid,
  output logic [W-1:0] Rdata,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  localparam int            CW   = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXBURST);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rr_gnt;
  logic [1:0]    gnt_raw;
  logic          own;
  logic          oth;
  logic [1:0]    rd_gnt;

  rr_pick2 u_pick (
    .req (Req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  assign own = (state_q == OWN1);
  assign oth = ~own;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    gnt_raw = 2'b00;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_raw = rr_gnt;
        if (rr_gnt[REQ_CORE]) begin
          ptr_d = 1'b1;
          if (Lock[REQ_CORE]) begin
            state_d = OWN0;
            cnt_d   = CW'(1);
          end
        end else if (rr_gnt[REQ_LOADER]) begin
          ptr_d = 1'b0;
          if (Lock[REQ_LOADER]) begin
            state_d = OWN1;
            cnt_d   = CW'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (!Req[own] || (cnt_q == MAXC && Req[oth])) begin
          // Owner released or exhausted its burst: hand over without a bubble.
          state_d = IDLE;
          cnt_d   = '0;
          if (Req[oth]) begin
            gnt_raw[oth] = 1'b1;
            ptr_d        = own;
          end
        end else begin
          gnt_raw[own] = 1'b1;
          if (cnt_q != MAXC) cnt_d = cnt_q + CW'(1);
          if (!Lock[own]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset masks the grant combinationally so no access leaks out while held.
  assign Gnt        = gnt_raw & {2{Reset}};
  assign MemWriteEn = |(Gnt & We);
  assign MemAddress = Gnt[REQ_LOADER] ? Addr1  : Addr0;
  assign MemDataIn  = Gnt[REQ_LOADER] ? Wdata1 : Wdata0;
  assign rd_gnt     = Gnt & ~We;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      Rvalid  <= 2'b00;
      Rdata   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      Rvalid  <= rd_gnt;
      if (|rd_gnt) Rdata <= MemDataOut;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W, default 8, data width in bits.
REQ-002 Parameter A, default 8, address width in bits (2**A entries).
REQ-003 Parameter MAXBURST, default 4, maximum consecutive locked grants to one requester while the other is requesting.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Req[1:0]  in  2  per-requester access request; 0 = core, 1 = loader.
- Lock[1:0]  in  2  per-requester burst lock, sampled with Req.
- We[1:0]  in  2  per-requester write enable; 0 = read.
- Addr0, Addr1  in  A  per-requester address.
- Wdata0, Wdata1  in  W  per-requester write data.
- Gnt[1:0]  out  2  one-hot-or-zero grant; access performed in the Gnt cycle.
- Rvalid[1:0]  out  2  read data valid, one cycle after a granted read.
- Rdata  out  W  registered read data, shared by both requesters.
- MemWriteEn  out  1  to single-port memory write enable.
- MemAddress  out  A  to memory address.
- MemDataIn  out  W  to memory write data.
- MemDataOut  in  W  from memory, combinational read of MemAddress.

Function
REQ-005 Gnt SHALL be combinational from Req and the current state; at most one bit set per cycle.
REQ-006 A requester SHALL hold Req, We, Addr, Wdata and Lock stable until it sees Gnt; each Gnt-high cycle completes exactly one access.
REQ-007 Mux: MemAddress/MemDataIn SHALL come from the granted requester; MemWriteEn = We of the granted requester AND Gnt; with no grant, MemWriteEn = 0 and MemAddress = Addr0.
REQ-008 On a granted read, Rdata SHALL capture MemDataOut at the clock edge ending the Gnt cycle, with the matching Rvalid bit high for exactly the next cycle; Rdata SHALL hold its value otherwise.
REQ-009 Granted writes SHALL NOT assert Rvalid.
REQ-010 FSM states: IDLE, OWN0, OWN1 (requester owning the lock).
REQ-011 IDLE: single requester -> granted; both requesting -> round-robin by priority pointer (reset value 0 = core first); the pointer SHALL move to the non-granted requester after each IDLE grant.
REQ-012 IDLE -> OWNn when requester n is granted with Lock[n]=1; burst counter loads 1.
REQ-013 OWNn: requester n SHALL have absolute priority; each grant to n increments the burst counter (saturates at MAXBURST).
REQ-014 OWNn -> IDLE when Req[n]=0, when Lock[n]=0 on a grant, or when the counter equals MAXBURST and the other requester is requesting; in the MAXBURST case the other requester SHALL be granted in the same cycle and the pointer set to n.
REQ-015 OWNn with Req[n]=0 and other requesting: the other SHALL be granted that cycle (no idle bubble).
REQ-016 Burst counter width SHALL be $clog2(MAXBURST+1); MAXBURST=1 means lock never starves the other requester beyond one access.
REQ-017 Simultaneous Lock from both requesters in IDLE: the round-robin winner SHALL take ownership.

Reset
REQ-018 While Reset=0: state IDLE, pointer 0, burst counter 0, Rdata 0, Rvalid 00; Gnt 00 and MemWriteEn 0 regardless of Req.
REQ-019 Reset asserted mid-burst or between Gnt and Rvalid SHALL abort the pending Rvalid; no memory write occurs while Reset=0.

Structure
REQ-020 Shared package mem_pkg SHALL hold the FSM state enum (IDLE, OWN0, OWN1) and requester index constants REQ_CORE=0, REQ_LOADER=1.
REQ-021 One sub-module, rr_pick2 (2-way round-robin selector with pointer input), SHALL be used; the memory is instantiated outside this block.

Verification
REQ-022 Req=01, We0=1, Addr0=0x10, Wdata0=0xA5 -> Gnt=01, MemWriteEn=1, MemAddress=0x10 that cycle; a following read of 0x10 yields Rdata=0xA5, Rvalid=01 one cycle later.
REQ-023 Req=11 held, Lock=00, reads -> Gnt alternates 01,10,01,10; Rvalid tracks with one-cycle delay.
REQ-024 Lock0=1, Req=11 continuous, MAXBURST=4 -> Gnt=01 for 4 cycles, then 10 for 1 cycle, then core regains.
REQ-025 OWN1, loader drops Req while core requests -> core granted the same cycle, state IDLE next.
REQ-026 Reset driven low the cycle after a granted read -> Rvalid stays 00, Rdata=0, Gnt=00; after release, first Req=11 grants core.
REQ-027 Req=00 for many cycles -> MemWriteEn=0, Gnt=00, Rdata unchanged.
